// File: rtl/serial_word_tx.sv
// Serial word transmitter: valid/ready word in, MSB-first bitstream out with frame enable and done pulse.
// Define SERIAL_WORD_TX_PARITY_EN to append an even-parity bit to every frame.
module serial_word_tx #(
   parameter int WIDTH = 8
) (
   input  logic             ck,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic             ready,
   output logic             dout,
   output logic             dout_en,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

`ifdef SERIAL_WORD_TX_PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
   logic r_par;
`else
   typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
`endif

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_shreg;
   logic [CW-1:0]    r_cnt;
   logic             w_last_data;
   logic             w_xfer;

   assign w_last_data = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));
   assign w_xfer      = load & ready;

   // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_xfer) w_next_state = S_SHIFT;
         end
         S_SHIFT: begin
            if (w_last_data) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
               w_next_state = S_PAR;
`else
               w_next_state = w_xfer ? S_SHIFT : S_IDLE;
`endif
            end
         end
`ifdef SERIAL_WORD_TX_PARITY_EN
         S_PAR: begin
            w_next_state = w_xfer ? S_SHIFT : S_IDLE;
         end
`endif
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: every output gets a default first so no latch is inferred.
   always_comb begin
      ready   = 1'b0;
      dout    = 1'b0;
      dout_en = 1'b0;
      done    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            ready = 1'b1;
         end
         S_SHIFT: begin
            dout    = r_shreg[WIDTH-1];
            dout_en = 1'b1;
`ifndef SERIAL_WORD_TX_PARITY_EN
            ready   = w_last_data;
            done    = w_last_data;
`endif
         end
`ifdef SERIAL_WORD_TX_PARITY_EN
         S_PAR: begin
            dout    = r_par;
            dout_en = 1'b1;
            ready   = 1'b1;
            done    = 1'b1;
         end
`endif
         default: begin
            ready = 1'b0;
         end
      endcase
   end

   // Counter holds at WIDTH-1 on the last data bit so it never wraps inside a frame.
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         r_shreg <= '0;
         r_cnt   <= '0;
      end else if (w_xfer) begin
         r_shreg <= din;
         r_cnt   <= '0;
      end else if (r_state == S_SHIFT) begin
         r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
         if (!w_last_data) r_cnt <= r_cnt + CW'(1);
      end
   end

`ifdef SERIAL_WORD_TX_PARITY_EN
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         r_par <= 1'b0;
      end else if (w_xfer) begin
         r_par <= ^din;
      end
   end
`endif

endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench for serial_word_tx: each transfer queues its expected bits; a negedge monitor pops and compares.
module tb_serial_word_tx;

   localparam int W = 8;

   logic         ck;
   logic         rst;
   logic         load;
   logic [W-1:0] din;
   logic         ready;
   logic         dout;
   logic         dout_en;
   logic         done;

   typedef struct packed {
      logic b;
      logic last;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   serial_word_tx #(.WIDTH(W)) dut (
      .ck      (ck),
      .rst     (rst),
      .load    (load),
      .din     (din),
      .ready   (ready),
      .dout    (dout),
      .dout_en (dout_en),
      .done    (done)
   );

   initial begin
      ck = 1'b0;
      forever #5 ck = ~ck;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [W-1:0] w);
      exp_t e;
`ifdef SERIAL_WORD_TX_PARITY_EN
      const bit par = 1'b1;
`else
      const bit par = 1'b0;
`endif
      for (int k = W - 1; k >= 0; k--) begin
         e.b    = w[k];
         e.last = (k == 0) && !par;
         q.push_back(e);
      end
      if (par) begin
         e.b    = ^w;
         e.last = 1'b1;
         q.push_back(e);
      end
   endtask

   // Present w from a negedge, wait (bounded) for ready, transfer on the next posedge.
   task automatic send(input logic [W-1:0] w);
      int n = 0;
      @(negedge ck);
      load = 1'b1;
      din  = w;
      while (!ready && n < 200) begin
         @(negedge ck);
         n++;
      end
      check("send_ready", {31'd0, ready}, 32'd1);
      @(posedge ck);
      #1;
      load = 1'b0;
      din  = ~w;
      push_frame(w);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 100) begin
         @(negedge ck);
         n++;
      end
      check("drain_empty", q.size(), 0);
      @(negedge ck);
   endtask

   // Monitor: a queued bit means the DUT must be mid-frame; an empty queue means idle outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge ck);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("dout_en_frame", {31'd0, dout_en}, 32'd1);
            check("dout_bit", {31'd0, dout}, {31'd0, e.b});
            check("done_bit", {31'd0, done}, {31'd0, e.last});
            check("ready_bit", {31'd0, ready}, {31'd0, e.last});
         end else begin
            check("idle_dout", {31'd0, dout}, 32'd0);
            check("idle_dout_en", {31'd0, dout_en}, 32'd0);
            check("idle_done", {31'd0, done}, 32'd0);
            check("idle_ready", {31'd0, ready}, 32'd1);
         end
      end
   end

   initial begin
      rst  = 1'b0;
      load = 1'b0;
      din  = '0;
      #12;
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_dout_en", {31'd0, dout_en}, 32'd0);
      @(negedge ck);
      rst = 1'b1;

      // Single word, then idle gap.
      send(8'hA5);
      drain();
      repeat (2) @(negedge ck);

      // Back-to-back frames with zero gap.
      send(8'hA5);
      send(8'h3C);
      drain();

      // Load held while busy must be ignored.
      send(8'hF0);
      load = 1'b1;
      din  = 8'h0F;
      repeat (6) @(posedge ck);
      #1;
      load = 1'b0;
      drain();

      // Asynchronous reset during bit 4 of 8'hFF.
      send(8'hFF);
      repeat (3) @(posedge ck);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_dout", {31'd0, dout}, 32'd0);
      check("midrst_dout_en", {31'd0, dout_en}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_ready", {31'd0, ready}, 32'd1);
      q.delete();
      @(negedge ck);
      @(negedge ck);
      rst = 1'b1;
      send(8'h81);
      drain();

      // Parity vectors (8 bits each when parity is compiled out).
      send(8'h07);
      send(8'h03);
      drain();

      // Continuous stream of mixed words.
      send(8'h00);
      send(8'hFF);
      send(8'h5A);
      send(8'hC3);
      send(8'h80);
      send(8'h01);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Serial word transmitter that generates the bitstream consumed by the team's serial sequence detectors. It accepts a parallel word through a valid/ready handshake and shifts it out MSB-first, one bit per clock, on a single-bit serial line. A frame-enable qualifier and an end-of-word pulse are provided. An optional even-parity bit can be appended to each word.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32.
- ck  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- load  input  1  word valid; a transfer occurs on a rising edge where load=1 and ready=1.
- din  input  WIDTH  parallel word; sampled only on a transfer edge.
- ready  output  1  transmitter can accept a word this cycle.
- dout  output  1  serial data, MSB first.
- dout_en  output  1  dout carries a frame bit this cycle.
- done  output  1  one-cycle pulse on the last bit of a frame.

## Operation
- Reset values: state=IDLE, shift register=0, bit counter=0, dout=0, dout_en=0, done=0, ready=1.
- IDLE state:
  - ready=1, dout=0, dout_en=0.
  - On a transfer: load the shift register with din, clear the counter, go to SHIFT.
  - If PARITY is compiled in, also latch ^din.
- SHIFT state:
  - dout=shreg[WIDTH-1], dout_en=1.
  - Each edge: shift left by one (zero fill) and increment the counter.
  - The last data bit is the cycle where counter==WIDTH-1.
- Leaving SHIFT after the last data bit:
  - Parity compiled in: go to PAR.
  - Parity compiled out, with a transfer on that edge: reload the shift register and stay in SHIFT (back-to-back frames).
  - Parity compiled out, no transfer: go to IDLE.
- PAR state (parity build only):
  - dout=latched parity, dout_en=1.
  - ready follows the same last-bit rule as SHIFT: a transfer here goes straight to SHIFT; otherwise go to IDLE.
- ready is a combinational output: 1 in IDLE, and 1 during the final bit of a frame. It is 0 at all other times.
- load while ready=0 is ignored. din is not captured and the frame in flight is unaffected.
- done=1 exactly during the final bit of a frame: the last data bit, or the parity bit when parity is compiled in.
- Counter width: $clog2(WIDTH). The counter never wraps mid-frame; it is cleared on every transfer.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronously). The partial frame is discarded and is not resumed.
- din changing outside the transfer edge has no effect.

## Timing
- Latency: transfer edge at cycle T puts din[WIDTH-1] on dout in cycle T+1. Bit din[WIDTH-1-k] appears in cycle T+1+k.
- Frame length: WIDTH cycles, or WIDTH+1 with parity. dout_en is continuously high for the whole frame.
- Back-to-back: a transfer during the final-bit cycle produces the next frame's MSB in the immediately following cycle. There is zero gap and dout_en stays high.
- Outputs dout, dout_en and done depend only on registered state; there is no combinational path from load or din.
- ready depends only on state and counter; it does not depend on load.
- First transfer is possible on the first rising edge after rst deasserts.

## Configuration
- Macro: SERIAL_WORD_TX_PARITY_EN.
- Defined:
  - Adds the PAR state and a parity register.
  - Each frame is WIDTH+1 bits; the last bit is the even-parity bit (XOR of din).
  - done and ready move to the parity cycle.
- Undefined:
  - No PAR state or parity register is synthesized.
  - Each frame is WIDTH bits.
  - done and ready occur on the last data bit.

## Test plan
- Reset then single word: WIDTH=8, transfer 8'hA5 at T.
  - dout = 1,0,1,0,0,1,0,1 over T+1..T+8, with dout_en=1 throughout.
  - done=1 only at T+8; ready=0 over T+1..T+7 and 1 at T+8.
  - dout=0 and dout_en=0 from T+9.
- Back-to-back: transfer 8'hA5, then 8'h3C on the edge ending its final bit.
  - 16 contiguous bits 10100101 00111100 with dout_en never dropping.
  - done pulses at bit 8 and bit 16.
- Load while busy: transfer 8'hF0, then hold load=1 with din=8'h0F for cycles T+1..T+6.
  - Output is exactly 11110000; load during busy cycles is ignored.
- Reset mid-frame: assert rst low at bit 4 of 8'hFF, asynchronously between edges.
  - dout, dout_en and done go to 0 immediately; ready goes to 1.
  - After release, transfer 8'h81 gives 10000001.
- Parity build (SERIAL_WORD_TX_PARITY_EN defined): transfer 8'h07, then 8'h03.
  - First frame: 00000111 followed by parity bit 1.
  - Second frame: 00000011 followed by parity bit 0.
  - Each frame is 9 cycles, with done on the 9th.
- Loopback: drive dout into the sequence detector's din with a random word stream.
  - Detector output must match the reference-model output computed on the concatenated bitstream.
